// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate-sensor interface: direction codes,
// generator FSM state encodings and the {a,b} pattern driven in each state.
package parking_pkg;

   // Direction of a vehicle command; enter means sensor A leads, exit means B leads
   localparam logic DIR_ENTER = 1'b0;
   localparam logic DIR_EXIT  = 1'b1;

   // Sequence generator states; P1..P3 are the three non-zero sensor phases
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      P1   = 3'd1,
      P2   = 3'd2,
      P3   = 3'd3,
      GAP  = 3'd4
   } state_t;

   // {a,b} for a given state and direction. Consecutive phases differ in
   // exactly one sensor, which is what the parking decoder relies on.
   function automatic logic [1:0] sensor_pattern(input state_t st, input logic dir);
      logic [1:0] ab;
      ab = 2'b00;
      case (st)
         P1:      ab = (dir == DIR_ENTER) ? 2'b10 : 2'b01;
         P2:      ab = 2'b11;
         P3:      ab = (dir == DIR_ENTER) ? 2'b01 : 2'b10;
         default: ab = 2'b00;
      endcase
      return ab;
   endfunction

endpackage

// File: rtl/parking_cmd_fifo.sv
// Command queue for the sensor pattern generator. First-word fall-through:
// the head entry is visible on pop_data whenever empty is low, so the FSM can
// load a command in the same cycle it pops it.
module parking_cmd_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   // Pointer arithmetic relies on natural wrap-around, so the depth must be a power of two
   generate
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
         $error("parking_cmd_fifo: DEPTH must be a power of two and at least 2");
      end
   endgenerate

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             push_en;
   logic             pop_en;

   // A push while full is dropped even if a pop happens in the same cycle
   assign push_en  = push && !full;
   assign pop_en   = pop && !empty;
   assign full     = (count_reg == FULL_CNT);
   assign empty    = (count_reg == '0);
   assign pop_data = mem[rd_ptr_reg];

   // Pointer and occupancy tracking; simultaneous push and pop leaves the count unchanged
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_en) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_en) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push_en, pop_en})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage array; contents need no reset because occupancy gates every read
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

endmodule

// File: rtl/parking_sensor_gen.sv
// Gate-sensor pattern generator: takes queued enter/exit commands and plays
// the matching two-sensor sequence on a/b, followed by a short all-clear gap.
module parking_sensor_gen #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic             cmd_dir,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             cmd_ready,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             done_dir
);

   import parking_pkg::*;

   // Gap counter runs 1..GAP_CYCLES, so it needs room for GAP_CYCLES itself
   localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
   localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYCLES);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

   // A zero-length gap would merge consecutive sequences into one pattern
   generate
      if (GAP_CYCLES < 1) begin : g_gap_check
         $error("parking_sensor_gen: GAP_CYCLES must be at least 1");
      end
   endgenerate

   // Queue interface
   logic               fifo_push;
   logic               fifo_pop;
   logic [LEN_W:0]     fifo_din;
   logic [LEN_W:0]     fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic [LEN_W-1:0]   cmd_len_eff;

   // FSM and datapath state
   state_t             state_reg,   state_next;
   logic               dir_reg,     dir_next;
   logic [LEN_W-1:0]   len_reg,     len_next;
   logic [LEN_W-1:0]   cnt_reg,     cnt_next;
   logic [GW-1:0]      gap_cnt_reg, gap_cnt_next;

   // Registered outputs
   logic               a_reg,        a_next;
   logic               b_reg,        b_next;
   logic               done_reg,     done_next;
   logic               done_dir_reg, done_dir_next;

   logic               phase_end;
   logic               gap_end;
   logic               load_cmd;

   // Length is normalised at push time so the queue only ever holds L >= 1
   assign cmd_len_eff = (cmd_len == '0) ? LEN_ONE : cmd_len;
   assign fifo_din    = {cmd_dir, cmd_len_eff};
   assign fifo_push   = cmd_valid && cmd_ready;
   assign cmd_ready   = !fifo_full;

   parking_cmd_fifo #(
      .WIDTH (LEN_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_din),
      .pop       (fifo_pop),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Phase counter counts 1..L and is compared for equality, so L = 2^LEN_W-1 never wraps
   assign phase_end = (cnt_reg == len_reg);
   assign gap_end   = (gap_cnt_reg == GAP_LAST);

   // State and datapath registers; reset abandons any partial sequence
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         dir_reg     <= DIR_ENTER;
         len_reg     <= LEN_ONE;
         cnt_reg     <= LEN_ONE;
         gap_cnt_reg <= GW'(1);
      end else begin
         state_reg   <= state_next;
         dir_reg     <= dir_next;
         len_reg     <= len_next;
         cnt_reg     <= cnt_next;
         gap_cnt_reg <= gap_cnt_next;
      end
   end

   // Next-state logic; a command is loaded straight out of IDLE or the end of a gap
   always_comb begin
      state_next   = state_reg;
      dir_next     = dir_reg;
      len_next     = len_reg;
      cnt_next     = cnt_reg;
      gap_cnt_next = gap_cnt_reg;
      load_cmd     = 1'b0;
      fifo_pop     = 1'b0;

      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               load_cmd = 1'b1;
            end
         end
         P1: begin
            if (phase_end) begin
               state_next = P2;
               cnt_next   = LEN_ONE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         P2: begin
            if (phase_end) begin
               state_next = P3;
               cnt_next   = LEN_ONE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         P3: begin
            if (phase_end) begin
               state_next   = GAP;
               gap_cnt_next = GW'(1);
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         GAP: begin
            if (gap_end) begin
               if (!fifo_empty) begin
                  load_cmd = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               gap_cnt_next = gap_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Back-to-back commands go directly to P1 with no idle cycle in between
      if (load_cmd) begin
         fifo_pop   = 1'b1;
         state_next = P1;
         dir_next   = fifo_dout[LEN_W];
         len_next   = fifo_dout[LEN_W-1:0];
         cnt_next   = LEN_ONE;
      end
   end

   // Output decode from the upcoming state so a/b/done are registered yet aligned with the state
   always_comb begin
      a_next        = 1'b0;
      b_next        = 1'b0;
      done_next     = 1'b0;
      done_dir_next = 1'b0;
      {a_next, b_next} = sensor_pattern(state_next, dir_next);
      if ((state_reg == P3) && (state_next == GAP)) begin
         done_next     = 1'b1;
         done_dir_next = dir_reg;
      end
   end

   // Output registers; reset forces the sensors to all-clear immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_reg        <= 1'b0;
         b_reg        <= 1'b0;
         done_reg     <= 1'b0;
         done_dir_reg <= 1'b0;
      end else begin
         a_reg        <= a_next;
         b_reg        <= b_next;
         done_reg     <= done_next;
         done_dir_reg <= done_dir_next;
      end
   end

   assign a        = a_reg;
   assign b        = b_reg;
   assign done     = done_reg;
   assign done_dir = done_dir_reg;
   assign busy     = (state_reg != IDLE) || !fifo_empty;

endmodule
